mult_result_accumulator: RTL and testbench
==========================================

Name: mult_result_accumulator

Overview:
Downstream stage of the 16x16 / dual-8x8-sum multiplier. It takes the multiplier's two partial-sum vectors plus SIMD lane carries and resolves them into final products. It then accumulates the products over a run of beats framed by a last marker, and presents the accumulated result with a one-cycle valid pulse. In full mode it holds one wide accumulator; in SIMD mode it holds two independent lane accumulators.

Parameters:
ACC_W, 48, full-mode accumulator width (must be >= 34)
LANE_W, 24, per-lane accumulator width in SIMD mode (must be >= 18; 2*LANE_W <= ACC_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  beat present on result inputs this cycle
in_last  input  1  final beat of a run; meaningful only with in_valid
mode  input  1  0 = 16x16 full, 1 = sum of two 8x8 per lane
sign  input  1  products signed (a_sign|b_sign of the beat)
result_0  input  32  partial-sum vector 0 from multiplier
result_1  input  32  partial-sum vector 1 from multiplier
result_SIMD_carry  input  2  lane carry bits from multiplier
acc_out  output  ACC_W  final accumulation; SIMD: {lane1 sign-ext to ACC_W-LANE_W... packed as lane1 in [2*LANE_W-1:LANE_W], lane0 in [LANE_W-1:0], upper bits zero}
out_valid  output  1  one-cycle pulse, acc_out valid
out_mode  output  1  mode of the run being reported
overflow  output  2  per-accumulator overflow seen in reported run (full mode uses bit 0)
busy  output  1  run in progress

Behaviour:
- Reset: acc_out=0, out_valid=0, out_mode=0, overflow=0, busy=0, FSM=IDLE, all internal accumulators and pipeline registers 0.
- Stage 1 (resolve, registered):
  - mode 0: prod = result_0 + result_1, 32-bit. Extend to ACC_W: sign-extend if sign, else zero-extend.
  - mode 1, per lane k: lane_k = {1'b0, r0[16k+15:16k]} + {1'b0, r1[16k+15:16k]} + (result_SIMD_carry[k] << 16). Take this as 17 bits; there is no carry between lanes. Sign-extend from bit 16 to LANE_W if sign, else zero-extend.
  - Stage 1 captures valid, last, mode and sign alongside.
- Stage 2 (accumulate): operand order is acc <= acc + resolved product. Latency from input beat to its inclusion in acc is 2 cycles. out_valid asserts 2 cycles after the in_last beat, and acc_out includes that beat.
- FSM states IDLE and RUN:
  - IDLE: in_valid -> latch run mode from this beat, load acc with the beat (not add), go to RUN. If in_last is also set, emit result and stay in IDLE. A single-beat run is legal.
  - RUN: each valid beat adds. A valid beat with in_last emits acc_out = acc + beat, pulses out_valid, and returns to IDLE.
  - Cycles with in_valid=0 are bubbles; they hold state.
- Mode lock: the mode input on non-first beats is ignored; the run mode applies. out_mode reports the run mode.
- Back-to-back runs: a first beat of a new run may arrive the cycle after in_last. It loads, never adds to the previous total. No bubble is required.
- Arithmetic: two's-complement wrap at ACC_W / LANE_W by default. overflow[k] sets sticky within a run when a signed (sign=1) or unsigned add overflows the accumulator width. It clears on run start and is reported with out_valid.
- acc_out holds its last reported value between pulses.
- Reset mid-run: the run is discarded, no out_valid, and everything returns to reset values the next cycle.
- busy is 1 from the cycle after the first beat is accepted until out_valid is emitted.

Optional Feature:
MULT_ACC_SATURATE_EN
- Defined: on overflow, the accumulator clamps to max/min for the active signedness and width, and the overflow flag still sets.
- Undefined: wrap-around only.
- Latency is unchanged in both builds.

Decomposition:
- Shared package: mode encodings MODE_FULL=1'b0 and MODE_SUM8=1'b1, the FSM state enum, and lane width constants (lane input 16, lane carry weight 16).
- One natural sub-module, mult_acc_lane_adder: a width-parameterised add with signed/unsigned overflow detect and optional saturation. It is instantiated once at ACC_W and twice at LANE_W, with a mode mux selecting between them.

Test Plan:
1. Full mode, unsigned, 3 beats with r0+r1 = 100, 200, 300, last on the third beat -> out_valid 2 cycles after the last beat, acc_out=600, overflow=0.
2. Full mode, signed, single beat with r0=32'hFFFF_FF00, r1=0, in_valid and in_last together -> acc_out = -256 sign-extended to 48 bits.
3. SIMD mode, unsigned:
   - Beat 1: lane0 halves 16'hFFFF+16'h0001, carry[0]=0 -> lane0=65536. Lane1 halves 0x0010+0x0020, carry[1]=1 -> lane1=65584.
   - Beat 2: same values, last.
   - Expected: lane0=131072, lane1=131168 in packed acc_out.
4. Back-to-back runs: run A=[5], last; next cycle run B=[7,9], last -> two pulses, acc_out 5 then 16. B never includes A.
5. Overflow: SIMD signed lane0 accumulates +65535 repeatedly until it exceeds 2^23-1 -> overflow[0]=1. acc_out is wrapped without MULT_ACC_SATURATE_EN and equals 24'h7FFFFF with it.
6. Reset mid-run after 2 beats, then a new single-beat run [3] -> no pulse for the aborted run; next pulse acc_out=3. Also check a mode toggle on beat 2 of a run is ignored (out_mode = first-beat mode).

Source files
------------

// File: rtl/mult_result_accumulator_pkg.sv
// Shared definitions for the multiplier result accumulator.
// Contents: mode encodings, FSM state type, lane geometry, stage-1 control payload.
package mult_result_accumulator_pkg;

   localparam logic MODE_FULL = 1'b0;   // one 16x16 product per beat
   localparam logic MODE_SUM8 = 1'b1;   // two lanes, each a sum of 8x8 products

   localparam int unsigned LANE_IN_W      = 16;             // lane slice of each result vector
   localparam int unsigned LANE_CARRY_POS = 16;             // weight of the lane carry bit
   localparam int unsigned LANE_RES_W     = LANE_IN_W + 1;  // resolved lane value width

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Control bits travelling alongside a resolved beat.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
      logic mode;
      logic sign;
   } beat_ctl_t;

endpackage

// File: rtl/mult_acc_lane_adder.sv
// Width-parameterised accumulate adder with signed/unsigned overflow detect.
// Build option: MULT_ACC_SATURATE_EN clamps the sum to the range limit on overflow.
// Ports:
//   a, b       addends (a = accumulator, b = resolved product)
//   is_signed  interpret operands as two's complement
//   sum_c      combinational sum (wrapped, or clamped when saturation is built in)
//   ovf_c      combinational overflow flag for the active signedness
module mult_acc_lane_adder #(
   parameter int unsigned W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         is_signed,
   output logic [W-1:0] sum_c,
   output logic         ovf_c
);

   logic [W:0] raw;
   logic       ovf_u;
   logic       ovf_s;

   always_comb begin
      raw   = {1'b0, a} + {1'b0, b};
      ovf_u = raw[W];
      // Signed overflow: like-signed operands producing a result of the other sign.
      ovf_s = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
      ovf_c = is_signed ? ovf_s : ovf_u;
      sum_c = raw[W-1:0];
`ifdef MULT_ACC_SATURATE_EN
      if (ovf_c) begin
         if (!is_signed)
            sum_c = '1;
         else if (a[W-1])
            sum_c = {1'b1, {(W-1){1'b0}}};
         else
            sum_c = {1'b0, {(W-1){1'b1}}};
      end
`endif
   end

endmodule

// File: rtl/mult_result_accumulator.sv
// Resolves multiplier partial-sum vectors into products and accumulates them
// over runs framed by in_last; one wide accumulator in full mode, two lane
// accumulators in SIMD mode. Build option: MULT_ACC_SATURATE_EN (saturating adds).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid, in_last, mode, sign    beat framing and attributes
//   result_0, result_1               partial-sum vectors
//   result_SIMD_carry                per-lane carry bits
//   acc_out, out_valid, out_mode     reported total, one-cycle pulse, run mode
//   overflow                         sticky per-accumulator overflow of the run
//   busy                             run in progress
module mult_result_accumulator
   import mult_result_accumulator_pkg::*;
#(
   parameter int unsigned ACC_W  = 48,
   parameter int unsigned LANE_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             mode,
   input  logic             sign,
   input  logic [31:0]      result_0,
   input  logic [31:0]      result_1,
   input  logic [1:0]       result_SIMD_carry,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   output logic             out_mode,
   output logic [1:0]       overflow,
   output logic             busy
);

   state_t state, state_nxt;
   logic   run_mode;
   logic   first_c;
   logic   eff_mode_c;

   // Run framing FSM, tracked at the input so mode lock applies to resolution.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = in_last ? ST_IDLE : ST_RUN;
         ST_RUN:  if (in_valid && in_last) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      first_c    = (state == ST_IDLE) && in_valid;
      eff_mode_c = (state == ST_RUN) ? run_mode : mode;
   end

   // Mode of the open run, captured from its first beat.
   always_ff @(posedge clk) begin
      if (reset)        run_mode <= MODE_FULL;
      else if (first_c) run_mode <= mode;
   end

   // Stage 1: resolve partial sums into products.
   logic [31:0]         sum32_c;
   logic [ACC_W-1:0]    full_prod_c;
   logic [LANE_RES_W-1:0] lane0_sum_c, lane1_sum_c;
   logic [LANE_W-1:0]   lane0_prod_c, lane1_prod_c;

   always_comb begin
      sum32_c      = result_0 + result_1;
      full_prod_c  = sign ? ACC_W'($signed(sum32_c)) : ACC_W'(sum32_c);
      // Lanes are independent 17-bit sums; no carry crosses between them.
      lane0_sum_c  = LANE_RES_W'(result_0[LANE_IN_W-1:0]) + LANE_RES_W'(result_1[LANE_IN_W-1:0])
                   + (LANE_RES_W'(result_SIMD_carry[0]) << LANE_CARRY_POS);
      lane1_sum_c  = LANE_RES_W'(result_0[2*LANE_IN_W-1:LANE_IN_W])
                   + LANE_RES_W'(result_1[2*LANE_IN_W-1:LANE_IN_W])
                   + (LANE_RES_W'(result_SIMD_carry[1]) << LANE_CARRY_POS);
      lane0_prod_c = sign ? LANE_W'($signed(lane0_sum_c)) : LANE_W'(lane0_sum_c);
      lane1_prod_c = sign ? LANE_W'($signed(lane1_sum_c)) : LANE_W'(lane1_sum_c);
   end

   beat_ctl_t        s1_ctl;
   logic [ACC_W-1:0]  s1_full;
   logic [LANE_W-1:0] s1_l0, s1_l1;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_ctl  <= '0;
         s1_full <= '0;
         s1_l0   <= '0;
         s1_l1   <= '0;
      end else begin
         s1_ctl <= '{valid: in_valid, first: first_c, last: in_valid & in_last,
                     mode: eff_mode_c, sign: sign};
         if (in_valid) begin
            s1_full <= full_prod_c;
            s1_l0   <= lane0_prod_c;
            s1_l1   <= lane1_prod_c;
         end
      end
   end

   // Stage 2: accumulate.
   logic [ACC_W-1:0]  acc_full;
   logic [LANE_W-1:0] acc_l0, acc_l1;
   logic [1:0]        ovf_q;
   logic [ACC_W-1:0]  sum_full_c;
   logic [LANE_W-1:0] sum_l0_c, sum_l1_c;
   logic              ovf_full_c, ovf_l0_c, ovf_l1_c;

   mult_acc_lane_adder #(.W(ACC_W)) u_full (
      .a(acc_full), .b(s1_full), .is_signed(s1_ctl.sign), .sum_c(sum_full_c), .ovf_c(ovf_full_c));
   mult_acc_lane_adder #(.W(LANE_W)) u_lane0 (
      .a(acc_l0), .b(s1_l0), .is_signed(s1_ctl.sign), .sum_c(sum_l0_c), .ovf_c(ovf_l0_c));
   mult_acc_lane_adder #(.W(LANE_W)) u_lane1 (
      .a(acc_l1), .b(s1_l1), .is_signed(s1_ctl.sign), .sum_c(sum_l1_c), .ovf_c(ovf_l1_c));

   logic [ACC_W-1:0]  acc_full_nxt;
   logic [LANE_W-1:0] acc_l0_nxt, acc_l1_nxt;
   logic [1:0]        ovf_hit_c, ovf_nxt;
   logic [ACC_W-1:0]  packed_c;

   // First beat of a run loads rather than adds, and restarts the sticky flags.
   always_comb begin
      acc_full_nxt = s1_ctl.first ? s1_full : sum_full_c;
      acc_l0_nxt   = s1_ctl.first ? s1_l0   : sum_l0_c;
      acc_l1_nxt   = s1_ctl.first ? s1_l1   : sum_l1_c;
      ovf_hit_c    = (s1_ctl.mode == MODE_SUM8) ? {ovf_l1_c, ovf_l0_c} : {1'b0, ovf_full_c};
      ovf_nxt      = s1_ctl.first ? 2'b00 : (ovf_q | ovf_hit_c);
      packed_c     = acc_full_nxt;
      if (s1_ctl.mode == MODE_SUM8) begin
         packed_c                      = '0;
         packed_c[LANE_W-1:0]          = acc_l0_nxt;
         packed_c[2*LANE_W-1:LANE_W]   = acc_l1_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_full  <= '0;
         acc_l0    <= '0;
         acc_l1    <= '0;
         ovf_q     <= '0;
         acc_out   <= '0;
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         overflow  <= '0;
         busy      <= 1'b0;
      end else begin
         out_valid <= s1_ctl.valid & s1_ctl.last;
         // Busy covers the open run plus the in-flight final beat.
         busy      <= in_valid | (state_nxt == ST_RUN);
         if (s1_ctl.valid) begin
            acc_full <= acc_full_nxt;
            acc_l0   <= acc_l0_nxt;
            acc_l1   <= acc_l1_nxt;
            ovf_q    <= ovf_nxt;
            if (s1_ctl.last) begin
               acc_out  <= packed_c;
               overflow <= ovf_nxt;
               out_mode <= s1_ctl.mode;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Self-checking bench for mult_result_accumulator: a reference model pushes the
// expected total of each run when its last beat is driven; a monitor collects
// reported totals, and each scenario task pops and compares them.
module tb_mult_result_accumulator;

   localparam int unsigned ACC_W  = 48;
   localparam int unsigned LANE_W = 24;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_last, mode, sign;
   logic [31:0]      result_0, result_1;
   logic [1:0]       result_SIMD_carry;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid, out_mode, busy;
   logic [1:0]       overflow;

   mult_result_accumulator #(.ACC_W(ACC_W), .LANE_W(LANE_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .mode(mode),
      .sign(sign), .result_0(result_0), .result_1(result_1),
      .result_SIMD_carry(result_SIMD_carry), .acc_out(acc_out), .out_valid(out_valid),
      .out_mode(out_mode), .overflow(overflow), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic             md;
      logic [1:0]       ov;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state.
   bit          m_in_run = 0;
   bit          m_mode   = 0;
   logic [63:0] m_full, m_l0, m_l1;
   logic [1:0]  m_ovf;

   always @(negedge clk)
      if (!reset && out_valid) obs_q.push_back('{acc_out, out_mode, overflow});

   task automatic model_add(input logic [63:0] a, input logic [63:0] b, input int w,
                            input bit sgn, output logic [63:0] r, output bit ov);
      logic [63:0] mask;
      longint      sa, sb, s, maxv, minv;
      mask = (64'd1 << w) - 64'd1;
      if (!sgn) begin
         r  = a + b;
         ov = (r > mask);
`ifdef MULT_ACC_SATURATE_EN
         if (ov) r = mask;
`endif
         r = r & mask;
      end else begin
         maxv = (longint'(1) << (w - 1)) - 1;
         minv = -(longint'(1) << (w - 1));
         sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
         sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
         s  = sa + sb;
         ov = (s > maxv) || (s < minv);
`ifdef MULT_ACC_SATURATE_EN
         if (ov) s = (s > maxv) ? maxv : minv;
`endif
         r = 64'(s) & mask;
      end
   endtask

   // Drive one valid beat for a cycle and advance the model.
   task automatic beat(input bit last, input bit md, input bit sg,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [1:0] cy);
      bit          eff, o;
      logic [31:0] p32;
      logic [16:0] l17 [2];
      logic [63:0] pf, pl [2];
      @(posedge clk); #1;
      in_valid = 1'b1; in_last = last; mode = md; sign = sg;
      result_0 = r0; result_1 = r1; result_SIMD_carry = cy;
      eff = m_in_run ? m_mode : md;
      p32 = r0 + r1;
      pf  = (sg && p32[31]) ? {32'h0000_FFFF, p32} : {32'h0, p32};
      for (int k = 0; k < 2; k++) begin
         l17[k] = 17'((r0 >> (16 * k)) & 32'hFFFF) + 17'((r1 >> (16 * k)) & 32'hFFFF)
                + (17'(cy[k]) << 16);
         pl[k]  = (sg && l17[k][16]) ? (64'(l17[k]) | 64'hFF_FFFE_0000) & 64'hFF_FFFF
                                     : 64'(l17[k]);
      end
      if (!m_in_run) begin
         m_mode = md; m_full = pf; m_l0 = pl[0]; m_l1 = pl[1]; m_ovf = 2'b00;
      end else if (eff == 1'b0) begin
         model_add(m_full, pf, ACC_W, sg, m_full, o); m_ovf[0] = m_ovf[0] | o;
      end else begin
         model_add(m_l0, pl[0], LANE_W, sg, m_l0, o); m_ovf[0] = m_ovf[0] | o;
         model_add(m_l1, pl[1], LANE_W, sg, m_l1, o); m_ovf[1] = m_ovf[1] | o;
      end
      if (last) begin
         exp_q.push_back('{eff ? ACC_W'((m_l1 << LANE_W) | m_l0) : ACC_W'(m_full), eff, m_ovf});
         m_in_run = 0;
      end else begin
         m_in_run = 1;
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_in_run = 0;
   endtask

   // Bounded wait for n reported results; a shortfall is caught by the caller.
   task automatic wait_obs(input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; in_last = 0; mode = 0; sign = 0;
      result_0 = '0; result_1 = '0; result_SIMD_carry = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (acc_out !== '0) begin errors++; $display("FAIL reset_acc got %h want 0", acc_out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", out_mode); end
      checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", overflow); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_full_unsigned();
      res_t o, e;
      beat(0, 0, 0, 32'd40, 32'd60, 2'b00);
      beat(0, 0, 0, 32'd150, 32'd50, 2'b00);
      beat(1, 0, 0, 32'd299, 32'd1, 2'b00);
      idle();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_lat1 got %b want 0", out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy1 got %b want 1", busy); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_lat2 got %b want 1", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy2 got %b want 0", busy); end
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL full_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.acc !== e.acc || o.acc !== 48'd600) begin errors++; $display("FAIL full_acc got %0d want %0d", o.acc, e.acc); end
         checks++; if (o.ov !== 2'b00) begin errors++; $display("FAIL full_ovf got %b want 00", o.ov); end
         checks++; if (o.md !== 1'b0) begin errors++; $display("FAIL full_mode got %b want 0", o.md); end
      end
   endtask

   task automatic test_full_signed_single();
      res_t o, e;
      beat(1, 0, 1, 32'hFFFF_FF00, 32'h0, 2'b00);
      idle();
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL signed_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.acc !== e.acc || o.acc !== 48'hFFFF_FFFF_FF00) begin errors++; $display("FAIL signed_acc got %h want %h", o.acc, e.acc); end
      end
   endtask

   task automatic test_simd();
      res_t o, e;
      beat(0, 1, 0, 32'h0010_FFFF, 32'h0020_0001, 2'b10);
      beat(1, 1, 0, 32'h0010_FFFF, 32'h0020_0001, 2'b10);
      idle();
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL simd_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.acc !== e.acc || o.acc !== 48'h020060_020000) begin errors++; $display("FAIL simd_acc got %h want %h", o.acc, e.acc); end
         checks++; if (o.md !== 1'b1) begin errors++; $display("FAIL simd_mode got %b want 1", o.md); end
         checks++; if (o.ov !== 2'b00) begin errors++; $display("FAIL simd_ovf got %b want 00", o.ov); end
      end
   endtask

   task automatic test_back_to_back();
      res_t o, e;
      beat(1, 0, 0, 32'd5, 32'd0, 2'b00);
      beat(0, 0, 0, 32'd7, 32'd0, 2'b00);
      beat(1, 0, 0, 32'd4, 32'd5, 2'b00);
      idle();
      wait_obs(2, 12);
      checks++;
      if (obs_q.size() < 2 || exp_q.size() < 2) begin
         errors++; $display("FAIL b2b_count got %0d want 2", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.acc !== e.acc || o.acc !== 48'd5) begin errors++; $display("FAIL b2b_a got %0d want %0d", o.acc, e.acc); end
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o.acc !== e.acc || o.acc !== 48'd16) begin errors++; $display("FAIL b2b_b got %0d want %0d", o.acc, e.acc); end
      end
   endtask

   task automatic test_overflow();
      res_t        o, e;
      logic [23:0] want_l0;
`ifdef MULT_ACC_SATURATE_EN
      want_l0 = 24'h7FFFFF;
`else
      want_l0 = 24'h80FF7F;
`endif
      for (int i = 0; i < 129; i++) beat(i == 128, 1, 1, 32'h0000_FFFF, 32'h0, 2'b00);
      idle();
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL ovf_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.ov !== e.ov || o.ov !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b want %b", o.ov, e.ov); end
         checks++; if (o.acc !== e.acc || o.acc[23:0] !== want_l0) begin errors++; $display("FAIL ovf_acc got %h want %h", o.acc, e.acc); end
      end
   endtask

   task automatic test_reset_mid_run();
      res_t o, e;
      beat(0, 0, 0, 32'd1, 32'd0, 2'b00);
      beat(0, 0, 0, 32'd2, 32'd0, 2'b00);
      do_reset();
      repeat (3) @(posedge clk);
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_pulse got %0d want 0", obs_q.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      beat(1, 0, 0, 32'd3, 32'd0, 2'b00);
      idle();
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL rerun_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.acc !== e.acc || o.acc !== 48'd3) begin errors++; $display("FAIL rerun_acc got %0d want %0d", o.acc, e.acc); end
      end
   endtask

   task automatic test_mode_lock();
      res_t o, e;
      beat(0, 0, 0, 32'd100, 32'd0, 2'b00);
      beat(1, 1, 0, 32'h0001_0002, 32'h0, 2'b11);
      idle();
      wait_obs(1, 10);
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
         errors++; $display("FAIL lock_count got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.md !== e.md || o.md !== 1'b0) begin errors++; $display("FAIL lock_mode got %b want %b", o.md, e.md); end
         checks++; if (o.acc !== e.acc || o.acc !== 48'd65638) begin errors++; $display("FAIL lock_acc got %0d want %0d", o.acc, e.acc); end
      end
   endtask

   initial begin
      test_reset();
      test_full_unsigned();
      test_full_signed_single();
      test_simd();
      test_back_to_back();
      test_overflow();
      test_reset_mid_run();
      test_mode_lock();
      repeat (4) @(posedge clk);
      checks++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         errors++; $display("FAIL leftover got obs=%0d exp=%0d want 0", obs_q.size(), exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
